// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Single-outstanding Wishbone pipelined-mode initiator. One command accepted
// on the cmd_* handshake becomes exactly one Wishbone read or write cycle.
// The cycle finishes with one rsp_valid_o pulse that carries a status code and,
// for successful reads, the read data.
//
// Handshake (cmd side): a command transfers on a rising clk edge where
// cmd_valid_i & cmd_ready_o are both high. cmd_ready_o is high only in IDLE,
// so no more than one transaction is ever in flight. rsp_valid_o is a
// one-cycle pulse and has no back-pressure.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake
//   cmd_we_i/adr_i/sel_i/dat_i  command fields (latched on accept)
//   rsp_valid_o            one-cycle completion pulse
//   rsp_status_o           00 ok, 01 err, 10 retry exhausted, 11 timeout
//   rsp_dat_o              read data (0 for writes and for non-ok status)
//   wb_*                   Wishbone pipelined initiator port
//   dbg_state_o            current FSM state (IDLE=0 REQ=1 WAIT=2 BACKOFF=3 RSP=4)
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int RETRY_MAX  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [1:0]            rsp_status_o,
    output logic [31:0]           rsp_dat_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_BACKOFF = 3'd3,
        S_RSP     = 3'd4
    } state_t;

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_ERR     = 2'b01;
    localparam logic [1:0]  ST_RTY     = 2'b10;
    localparam logic [1:0]  ST_TIMEOUT = 2'b11;

    localparam logic [7:0]  RETRY_LIM  = 8'(RETRY_MAX);
    // The counter reads 0 in the first stb cycle, so the abort decision is
    // taken when it holds TIMEOUT-1; cyc then drops TIMEOUT cycles after stb
    // first rose.
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  status_d;
    logic [31:0] rdat_d;
    logic        load_cmd;

    // Next-state / response decision. All Wishbone and handshake outputs are
    // derived from state_d and registered below, so every output is a flop.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        status_d = rsp_status_o;
        rdat_d   = rsp_dat_o;
        load_cmd = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    load_cmd = 1'b1;
                    retry_d  = '0;
                    tmo_d    = '0;
                    state_d  = S_REQ;
                end
            end

            // Termination is honoured in REQ even while stall is high: a
            // slave may release stall and ack in the same cycle.
            S_REQ, S_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                if (wb_err_i) begin
                    status_d = ST_ERR;
                    rdat_d   = '0;
                    state_d  = S_RSP;
                end else if (wb_rty_i) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_BACKOFF;
                    end else begin
                        status_d = ST_RTY;
                        rdat_d   = '0;
                        state_d  = S_RSP;
                    end
                end else if (wb_ack_i) begin
                    status_d = ST_OK;
                    rdat_d   = wb_we_o ? 32'd0 : wb_dat_i;
                    state_d  = S_RSP;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    rdat_d   = '0;
                    state_d  = S_RSP;
                end else if (state_q == S_REQ && !wb_stall_i) begin
                    state_d = S_WAIT;
                end
            end

            // One idle bus cycle before re-issuing the same command.
            S_BACKOFF: begin
                tmo_d   = '0;
                state_d = S_REQ;
            end

            S_RSP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            retry_q      <= '0;
            tmo_q        <= '0;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= '0;
            rsp_dat_o    <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            cmd_ready_o  <= (state_d == S_IDLE);
            rsp_valid_o  <= (state_d == S_RSP);
            rsp_status_o <= status_d;
            rsp_dat_o    <= rdat_d;
            wb_cyc_o     <= (state_d == S_REQ) || (state_d == S_WAIT);
            wb_stb_o     <= (state_d == S_REQ);
            if (load_cmd) begin
                wb_we_o  <= cmd_we_i;
                wb_adr_o <= cmd_adr_i;
                wb_sel_o <= cmd_sel_i;
                wb_dat_o <= cmd_dat_i;
            end
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Directed bench for wb_cmd_master (TIMEOUT=8, RETRY_MAX=3). A scripted
// Wishbone slave with a small register file answers each stb phase with a
// programmed termination. Expected responses are queued by the driver and
// compared by a monitor whenever rsp_valid_o pulses; bus activity counters
// (stb cycles, stb phases, cyc cycles, latency) are checked per command.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

    localparam int AW = 32;

    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ERR  = 2;
    localparam int K_RTY  = 3;
    localparam int K_ALL  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // ---------------- DUT signals ----------------
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [3:0]    cmd_sel = '0;
    logic [31:0]   cmd_dat = '0;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [31:0]   rsp_dat;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i = '0;
    logic          wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;
    logic [2:0]    dbg_state;

    wb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(8), .RETRY_MAX(3)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_sel_i    (cmd_sel),
        .cmd_dat_i    (cmd_dat),
        .rsp_valid_o  (rsp_valid),
        .rsp_status_o (rsp_status),
        .rsp_dat_o    (rsp_dat),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_adr_o     (wb_adr),
        .wb_sel_o     (wb_sel),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack),
        .wb_err_i     (wb_err),
        .wb_rty_i     (wb_rty),
        .wb_stall_i   (wb_stall),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [33:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scripted slave ----------------
    int          sl_stall_n = 0;   // stall cycles at start of each stb phase
    int          sl_delay = 0;     // cycles from stb accept to termination
    int          sl_kinds[8];      // termination per stb phase
    int          sl_pidx = 0;
    logic        sl_noise = 1'b0;  // drive err/ack while cyc is low
    int          sl_ph = 0;
    int          sl_k = 0;
    logic        sl_acc = 1'b0;
    logic [31:0] mem[4];

    always @(negedge clk) begin
        int kind;
        int idx;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rty   = 1'b0;
        wb_stall = 1'b0;
        wb_dat_i = 32'hA5A5_A5A5;
        if (!wb_cyc) begin
            sl_ph  = 0;
            sl_acc = 1'b0;
            sl_k   = 0;
            if (sl_noise) begin
                wb_err = 1'b1;
                wb_ack = 1'b1;
            end
        end else begin
            if (wb_stb && !sl_acc) begin
                if (sl_ph < sl_stall_n) begin
                    wb_stall = 1'b1;
                    sl_ph++;
                end else begin
                    sl_acc = 1'b1;
                    sl_k   = 0;
                end
            end
            if (sl_acc) begin
                if (sl_k == sl_delay) begin
                    kind = sl_kinds[sl_pidx];
                    sl_pidx++;
                    idx = int'(wb_adr[3:2]);
                    if (kind == K_ACK || kind == K_ALL) begin
                        wb_ack = 1'b1;
                        if (wb_we) begin
                            for (int b = 0; b < 4; b++)
                                if (wb_sel[b]) mem[idx][8*b +: 8] = wb_dat_o[8*b +: 8];
                        end else begin
                            wb_dat_i = mem[idx];
                        end
                    end
                    if (kind == K_ERR || kind == K_ALL) wb_err = 1'b1;
                    if (kind == K_RTY || kind == K_ALL) wb_rty = 1'b1;
                end
                sl_k++;
            end
        end
    end

    // ---------------- monitor ----------------
    int   mon_stb = 0, mon_ph = 0, mon_cyc = 0, rsp_cnt = 0, last_rsp_cycle = 0;
    logic stb_prev = 1'b0;

    always @(negedge clk) begin
        logic [33:0] e;
        if (wb_stb) mon_stb++;
        if (wb_stb && !stb_prev) mon_ph++;
        stb_prev = wb_stb;
        if (wb_cyc) mon_cyc++;
        if (rsp_valid) begin
            rsp_cnt++;
            last_rsp_cycle = cycle;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got status %0d data 0x%08h with nothing expected",
                         rsp_status, rsp_dat);
            end else begin
                e = exp_q.pop_front();
                check("rsp_status", {30'd0, rsp_status}, {30'd0, e[33:32]});
                check("rsp_dat", rsp_dat, e[31:0]);
                check("cyc_low_in_rsp", {31'd0, wb_cyc}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_kinds(input int k0, input int k1, input int k2, input int k3);
        sl_kinds[0] = k0; sl_kinds[1] = k1; sl_kinds[2] = k2; sl_kinds[3] = k3;
        for (int i = 4; i < 8; i++) sl_kinds[i] = K_NONE;
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [1:0] es, input logic [31:0] ed,
                           input int e_stb, input int e_ph, input int e_cyc, input int e_lat);
        int t0, s0, p0, c0, r0, n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) return;
        sl_pidx = 0;
        s0 = mon_stb; p0 = mon_ph; c0 = mon_cyc; r0 = rsp_cnt; t0 = cycle;
        exp_q.push_back({es, ed});
        cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt == r0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", {31'd0, rsp_cnt != r0}, 32'd1);
        @(negedge clk);
        check("latency", 32'(last_rsp_cycle - t0), 32'(e_lat));
        check("stb_cycles", 32'(mon_stb - s0), 32'(e_stb));
        check("stb_phases", 32'(mon_ph - p0), 32'(e_ph));
        check("cyc_cycles", 32'(mon_cyc - c0), 32'(e_cyc));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        set_kinds(K_ACK, K_NONE, K_NONE, K_NONE);

        // reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_wb_adr_dat", wb_adr | wb_dat_o | {28'd0, wb_sel} | {31'd0, wb_we}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        // 1: writes and read-back, zero-wait ack
        sl_stall_n = 0; sl_delay = 0;
        set_kinds(K_ACK, K_NONE, K_NONE, K_NONE);
        run_cmd(1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF, 2'b00, 32'h0, 1, 1, 1, 2);
        run_cmd(1'b1, 32'h4, 4'h5, 32'h1234_5678, 2'b00, 32'h0, 1, 1, 1, 2);
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 1, 1, 2);
        run_cmd(1'b0, 32'h4, 4'hF, 32'h0, 2'b00, 32'h0034_0078, 1, 1, 1, 2);

        // ack one cycle after the stb accept
        sl_delay = 1;
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 1, 2, 3);

        // 2: stall for 3 cycles, ack as stall drops
        sl_stall_n = 3; sl_delay = 0;
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 4, 1, 4, 5);
        sl_stall_n = 0;

        // 3: err two cycles after the stb accept
        sl_delay = 2;
        set_kinds(K_ERR, K_NONE, K_NONE, K_NONE);
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b01, 32'h0, 1, 1, 3, 4);
        sl_delay = 0;

        // err + rty + ack together: err wins
        set_kinds(K_ALL, K_NONE, K_NONE, K_NONE);
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b01, 32'h0, 1, 1, 1, 2);

        // 4: two retries then ack; bus noise while cyc is low must be ignored
        sl_noise = 1'b1;
        set_kinds(K_RTY, K_RTY, K_ACK, K_NONE);
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 3, 3, 3, 6);
        sl_noise = 1'b0;

        // 5: four retries exhausts RETRY_MAX=3
        set_kinds(K_RTY, K_RTY, K_RTY, K_RTY);
        run_cmd(1'b1, 32'h8, 4'hF, 32'h0BAD_F00D, 2'b10, 32'h0, 4, 4, 4, 8);

        // 6: no termination -> timeout after 8 cycles
        set_kinds(K_NONE, K_NONE, K_NONE, K_NONE);
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b11, 32'h0, 1, 1, 8, 9);

        // 6b: reset while waiting, no response may follow
        @(negedge clk);
        r0 = rsp_cnt;
        cmd_we = 1'b0; cmd_adr = 32'h0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_cyc_high", {30'd0, wb_cyc, wb_stb}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        check("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_rsp_after_rst", 32'(rsp_cnt - r0), 32'd0);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // normal operation after reset
        set_kinds(K_ACK, K_NONE, K_NONE, K_NONE);
        run_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 1, 1, 2);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Backstop in case a bounded wait is somehow bypassed.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Single-outstanding Wishbone pipelined-mode initiator. Converts a simple command/response handshake into one Wishbone read or write cycle. Handles stall, err, retry (rty) and bus timeout. Used by sequencers and test controllers to access wbgen/cheby-generated register slaves over the same Wishbone interface those slaves expose.

Parameters:
ADDR_WIDTH, 32, width of cmd_adr_i and wb_adr_o (byte address, passed through unchanged)
TIMEOUT, 255, cycles from stb assertion to forced abort; legal range 1..65535
RETRY_MAX, 3, number of re-issues after rty before reporting failure; 0 means no retry

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_we_i  in  1  1 = write, 0 = read
cmd_adr_i  in  ADDR_WIDTH  target address
cmd_sel_i  in  4  byte selects
cmd_dat_i  in  32  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_status_o  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout
rsp_dat_o  out  32  read data; 0 for writes and for non-ok status
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADDR_WIDTH  address
wb_sel_o  out  4  byte selects
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
wb_rty_i  in  1  retry
wb_stall_i  in  1  pipelined stall

Behaviour:
- All outputs are registered. Reset (async assert, sync deassert) forces: state IDLE; cmd_ready_o=1; wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o = 0; wb_adr_o, wb_sel_o, wb_dat_o, rsp_dat_o, rsp_status_o, retry and timeout counters = 0. Reset mid-cycle drops cyc/stb immediately; no response is produced.
- States: IDLE, REQ, WAIT, BACKOFF, RSP.
- IDLE: cmd_ready_o=1. On accept, latch we/adr/sel/dat onto wb_* outputs, clear the retry count, go to REQ. Next cycle cyc=stb=1.
- REQ: cyc=stb=1, bus outputs held stable. Termination (ack, err or rty) is sampled here regardless of stall, because slaves may drop stall in the same cycle as ack. Without termination: stall=0 -> WAIT with stb=0, cyc=1; stall=1 -> stay in REQ.
- WAIT: cyc=1, stb=0. Wait for ack, err or rty. Signals sampled while cyc=0 are ignored.
- Termination priority when several are high in one cycle: err > rty > ack.
  - ack: capture wb_dat_i if read, else 0; status 00; go to RSP.
  - err: status 01, data 0, go to RSP.
  - rty with retry count < RETRY_MAX: increment count, go to BACKOFF (cyc=stb=0 for one cycle), then REQ with the same command.
  - rty with retry count = RETRY_MAX: status 10, go to RSP.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT with no termination: drop cyc/stb, status 11, go to RSP. A termination in that same cycle takes precedence over the timeout.
- RSP: cyc=stb=0, rsp_valid_o=1 for exactly one cycle, then IDLE. rsp_dat_o and rsp_status_o hold until the next response.
- cmd_ready_o=0 in every state except IDLE. Exactly one transaction is outstanding at a time.
- Minimum latency, accept to rsp_valid_o, with zero-wait ack during the stb cycle: accept at cycle 0, stb at cycle 1, ack at cycle 1, rsp_valid_o at cycle 2, cmd_ready_o at cycle 3.

Test Plan:
1. Write 0xDEADBEEF to 0x0 (sel=0xF) against the generated threshold register slave, then read 0x0 -> two responses, status 00; the read returns 0xDEADBEEF; cyc is high only between accept+1 and response.
2. Stall held high 3 cycles, ack on the cycle stall drops -> stb high for 4 cycles; single response, status 00, read data captured.
3. err asserted 2 cycles after the stb accept -> status 01, rsp_dat_o=0, cyc low in the RSP cycle.
4. rty twice, then ack with RETRY_MAX=3 -> stb observed 3 times, each separated by one cyc-low cycle; status 00.
5. rty four times with RETRY_MAX=3 -> 4 stb phases, then status 10.
6. No termination with TIMEOUT=8 -> cyc drops 8 cycles after stb first asserts, status 11. Separately, assert rst_n_i low during WAIT -> cyc/stb low asynchronously; no rsp_valid_o; cmd_ready_o=1 after release.
